cursor_paleta_datapath: RTL and testbench
=========================================

CURSOR_PALETA_DATAPATH -- requirements
Module: cursor_paleta_datapath

Interface
REQ-001 SHALL have parameter BLINK_TICKS, 24'd6000000, clk cycles per blink phase (legal range 2..2^24-1).
REQ-002 SHALL have parameter FIFO_DEPTH, 4, pixel-write buffer entries (power of two, minimum 2).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 base_x, base_y  in  5 each  cursor origin on the 32x32 panel.
REQ-006 out_rst, rst_cont, plus, sum, Change_X, Change_Y, paint, Contar_Blanco_S, Contar_Negro_S  in  1 each  command strobes from the cursor controller.
REQ-007 px_data  in  8  pixel colour to write.
REQ-008 C  out  3  side-length counter.
REQ-009 CB, CN  out  1 each  white-phase-done and black-phase-done flags.
REQ-010 wr_valid  out  1; wr_ready  in  1; wr_addr  out  10 ({y,x}); wr_data  out  8  framebuffer write port with valid/ready handshake.
REQ-011 overflow  out  1  sticky flag: a paint was dropped.

Function
REQ-012 x_cur/y_cur (5 bit) SHALL load base_x/base_y on the clock edge where out_rst=1; out_rst overrides every other strobe.
REQ-013 Change_X=1 SHALL step x_cur by +1 if sum=1, else by -1; Change_Y SHALL step y_cur the same way; step takes effect on that edge.
REQ-014 Without CURSOR_CLIP_EN, steps SHALL wrap modulo 32 (31+1=0, 0-1=31).
REQ-015 paint=1 SHALL enqueue {y_cur,x_cur,px_data} using coordinates from before any step in the same cycle.
REQ-016 C SHALL clear to 0 on rst_cont or out_rst; otherwise increment mod 8 on plus=1; rst_cont has priority over plus.
REQ-017 A 24-bit blink counter SHALL increment while Contar_Blanco_S or Contar_Negro_S is 1, and clear when both are 0.
REQ-018 When the counter equals BLINK_TICKS-1 with Contar_Blanco_S=1: CB<=1, counter<=0.
REQ-019 When the counter equals BLINK_TICKS-1 with Contar_Negro_S=1: CN<=1, CB<=0, counter<=0; CN SHALL clear on rst_cont or out_rst.
REQ-020 CB SHALL remain set through rst_cont and clear only on out_rst or black-phase completion.
REQ-021 If both Contar_* are 1 in the same cycle, Contar_Negro_S SHALL take precedence.
REQ-022 FIFO: wr_valid=!empty; head entry drives wr_addr/wr_data; dequeue on wr_valid&&wr_ready; output is registered, so the first write is visible one cycle after paint.
REQ-023 Simultaneous enqueue and dequeue SHALL be legal at any fill level, including full.
REQ-024 A paint arriving while the FIFO is full with no dequeue that cycle SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-025 wr_addr/wr_data SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-026 out_rst SHALL NOT flush the FIFO; buffered writes drain normally.

Reset
REQ-027 When rst=0 at an edge: x_cur=0, y_cur=0, C=0, CB=0, CN=0, blink counter=0, FIFO empty, wr_valid=0, wr_addr=0, wr_data=0, overflow=0.
REQ-028 Reset mid-operation SHALL discard all buffered writes; no wr_valid in the cycle after reset.

Configuration
REQ-029 Macro CURSOR_CLIP_EN: when defined, x/y steps SHALL saturate at 0 and 31 (31+1=31, 0-1=0); when undefined, they wrap per REQ-014.

Verification
REQ-030 Reset, base=(3,7), out_rst, then 5x (paint+Change_X+sum) at wr_ready=1 -> writes at x=3..7, y=7, addr 227..231, in order.
REQ-031 base_x=31, Change_X+sum -> x_cur=0 without CURSOR_CLIP_EN; x_cur=31 with it; likewise base_y=0 with Change_Y, sum=0 -> 31 / 0.
REQ-032 BLINK_TICKS=4, Contar_Blanco_S held -> CB rises on the 4th edge; then Contar_Negro_S held -> CN=1 and CB=0 on the 4th edge; rst_cont -> CN=0 while CB stays 0.
REQ-033 FIFO_DEPTH=4, wr_ready=0, 6 paints -> 4 queued, overflow=1; wr_ready=1 -> exactly the first 4 entries drain, then wr_valid=0.
REQ-034 FIFO full, paint with wr_ready=1 in the same cycle -> no overflow, count stays 4.
REQ-035 rst=0 asserted with 3 entries queued -> next cycle wr_valid=0, C=0, overflow=0.

Source files
------------

// File: rtl/cursor_paleta_datapath.sv
// Cursor position, side counter, blink timer and buffered framebuffer writes.
// Define CURSOR_CLIP_EN to saturate cursor steps at the panel edges instead of wrapping.
module cursor_paleta_datapath #(
    parameter logic [23:0] BLINK_TICKS = 24'd6000000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] base_x,
    input  logic [4:0] base_y,
    input  logic       out_rst,
    input  logic       rst_cont,
    input  logic       plus,
    input  logic       sum,
    input  logic       Change_X,
    input  logic       Change_Y,
    input  logic       paint,
    input  logic       Contar_Blanco_S,
    input  logic       Contar_Negro_S,
    input  logic [7:0] px_data,
    output logic [2:0] C,
    output logic       CB,
    output logic       CN,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       overflow
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CONE_C  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE_C = AW'(1);
    localparam logic [23:0] LAST_C  = BLINK_TICKS - 24'd1;

    logic [4:0]  x_q, x_d, y_q, y_d;
    logic [2:0]  c_q, c_d;
    logic [23:0] bc_q, bc_d;
    logic        cb_q, cb_d, cn_q, cn_d;
    logic        ovf_q, ovf_d;
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        full, deq, enq;

    function automatic logic [4:0] step(input logic [4:0] v, input logic up);
`ifdef CURSOR_CLIP_EN
        if (up) return (v == 5'd31) ? v : v + 5'd1;
        else    return (v == 5'd0)  ? v : v - 5'd1;
`else
        return up ? v + 5'd1 : v - 5'd1;
`endif
    endfunction

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (out_rst) begin
            x_d = base_x;
            y_d = base_y;
        end else begin
            if (Change_X) x_d = step(x_q, sum);
            if (Change_Y) y_d = step(y_q, sum);
        end
    end

    always_comb begin
        c_d = c_q;
        if (rst_cont || out_rst) c_d = 3'd0;
        else if (plus)           c_d = c_q + 3'd1;
    end

    // Black phase completion wins over white; explicit clears win over both.
    always_comb begin
        bc_d = bc_q;
        cb_d = cb_q;
        cn_d = cn_q;
        if (Contar_Blanco_S || Contar_Negro_S) begin
            if (bc_q == LAST_C) begin
                bc_d = 24'd0;
                if (Contar_Negro_S) begin
                    cn_d = 1'b1;
                    cb_d = 1'b0;
                end else begin
                    cb_d = 1'b1;
                end
            end else begin
                bc_d = bc_q + 24'd1;
            end
        end else begin
            bc_d = 24'd0;
        end
        if (out_rst)             cb_d = 1'b0;
        if (rst_cont || out_rst) cn_d = 1'b0;
    end

    assign wr_valid = (cnt_q != '0);
    assign full     = (cnt_q == DEPTH_C);
    assign deq      = wr_valid && wr_ready;
    assign enq      = paint && (!full || deq);
    assign wr_addr  = mem_q[rp_q][17:8];
    assign wr_data  = mem_q[rp_q][7:0];

    always_comb begin
        wp_d  = enq ? wp_q + PONE_C : wp_q;
        rp_d  = deq ? rp_q + PONE_C : rp_q;
        ovf_d = ovf_q | (paint && full && !deq);
        cnt_d = cnt_q;
        unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CONE_C;
            2'b01:   cnt_d = cnt_q - CONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= 5'd0;
            y_q   <= 5'd0;
            c_q   <= 3'd0;
            bc_q  <= 24'd0;
            cb_q  <= 1'b0;
            cn_q  <= 1'b0;
            ovf_q <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            c_q   <= c_d;
            bc_q  <= bc_d;
            cb_q  <= cb_d;
            cn_q  <= cn_d;
            ovf_q <= ovf_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is cleared so the idle write port reads back as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 18'd0;
        end else if (enq) begin
            mem_q[wp_q] <= {y_q, x_q, px_data};
        end
    end

    assign C        = c_q;
    assign CB       = cb_q;
    assign CN       = cn_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cursor_paleta_datapath.sv
// Randomized + directed bench with a queue-based reference model and scoreboard.
module tb_cursor_paleta_datapath;

    localparam int BT = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] base_x = '0, base_y = '0;
    logic       out_rst = 0, rst_cont = 0, plus = 0, sum = 0;
    logic       Change_X = 0, Change_Y = 0, paint = 0;
    logic       Contar_Blanco_S = 0, Contar_Negro_S = 0;
    logic [7:0] px_data = '0;
    logic [2:0] C;
    logic       CB, CN, wr_valid, overflow;
    logic       wr_ready = 1'b0;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    cursor_paleta_datapath #(.BLINK_TICKS(24'd4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .base_x(base_x), .base_y(base_y),
        .out_rst(out_rst), .rst_cont(rst_cont), .plus(plus), .sum(sum),
        .Change_X(Change_X), .Change_Y(Change_Y), .paint(paint),
        .Contar_Blanco_S(Contar_Blanco_S), .Contar_Negro_S(Contar_Negro_S),
        .px_data(px_data), .C(C), .CB(CB), .CN(CN), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    int mx, my, mc, mcb, mcn, mcnt, mocc, movf;
    logic [17:0] sbq[$];
    logic [9:0]  seen[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mv(int v, bit up);
`ifdef CURSOR_CLIP_EN
        if (up) return (v < 31) ? v + 1 : 31;
        return (v > 0) ? v - 1 : 0;
`else
        return up ? (v + 1) % 32 : (v + 31) % 32;
`endif
    endfunction

    task automatic model();
        bit deq, done;
        if (!rst) begin
            mx = 0; my = 0; mc = 0; mcb = 0; mcn = 0;
            mcnt = 0; mocc = 0; movf = 0;
            sbq.delete();
            return;
        end
        deq = (mocc > 0) && wr_ready;
        if (paint) begin
            if (mocc < DEPTH || deq) begin
                sbq.push_back({5'(my), 5'(mx), px_data});
                mocc++;
            end else begin
                movf = 1;
            end
        end
        if (deq) mocc--;
        if (rst_cont || out_rst) mc = 0;
        else if (plus) mc = (mc + 1) % 8;
        done = 0;
        if (Contar_Blanco_S || Contar_Negro_S) begin
            if (mcnt == BT - 1) begin
                mcnt = 0;
                done = 1;
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
        if (done && Contar_Negro_S) begin
            mcn = 1; mcb = 0;
        end else if (done) begin
            mcb = 1;
        end
        if (out_rst) mcb = 0;
        if (rst_cont || out_rst) mcn = 0;
        if (out_rst) begin
            mx = base_x; my = base_y;
        end else begin
            if (Change_X) mx = mv(mx, sum);
            if (Change_Y) my = mv(my, sum);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        chk("C", 32'(C), 32'(mc));
        chk("CB", 32'(CB), 32'(mcb));
        chk("CN", 32'(CN), 32'(mcn));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic clr();
        out_rst = 0; rst_cont = 0; plus = 0; sum = 0;
        Change_X = 0; Change_Y = 0; paint = 0;
        Contar_Blanco_S = 0; Contar_Negro_S = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 0;
        tick();
        rst = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_valid", 32'(wr_valid), 32'(mocc > 0));
            if (wr_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sb_empty: got write %0d expected none", wr_addr);
                end else begin
                    logic [17:0] e;
                    e = sbq[0];
                    chk("wr_addr", 32'(wr_addr), 32'(e[17:8]));
                    chk("wr_data", 32'(wr_data), 32'(e[7:0]));
                    if (wr_ready) begin
                        sbq.delete(0);
                        seen.push_back(wr_addr);
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] e0, e1;
        rst = 0;
        clr();
        tick();
        tick();
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", 32'(wr_data), 0);
        rst = 1;
        mon_en = 1;

        // base (3,7) then five painted steps right
        base_x = 5'd3; base_y = 5'd7; out_rst = 1; wr_ready = 1;
        tick();
        clr();
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            paint = 1; Change_X = 1; sum = 1; px_data = 8'($urandom);
            tick();
        end
        clr();
        repeat (3) tick();
        chk("walk_n", 32'(seen.size()), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            chk("walk_addr", 32'(seen[i]), 32'(227 + i));

        // edges: x from 31 upward, y from 0 downward
`ifdef CURSOR_CLIP_EN
        e0 = 10'd31; e1 = 10'd31;
`else
        e0 = 10'd0;  e1 = 10'd992;
`endif
        seen.delete();
        base_x = 5'd31; base_y = 5'd0; out_rst = 1;
        tick();
        clr(); Change_X = 1; sum = 1;
        tick();
        clr(); paint = 1;
        tick();
        clr(); Change_Y = 1; sum = 0;
        tick();
        clr(); paint = 1;
        tick();
        clr();
        repeat (3) tick();
        chk("edge_n", 32'(seen.size()), 2);
        if (seen.size() == 2) begin
            chk("edge_x", 32'(seen[0]), 32'(e0));
            chk("edge_y", 32'(seen[1]), 32'(e1));
        end

        // blink phases
        Contar_Blanco_S = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("blink_cb", 32'(CB), 32'(i == 4));
        end
        Contar_Blanco_S = 0; Contar_Negro_S = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("blink_cn", 32'(CN), 32'(i == 4));
            chk("blink_cb2", 32'(CB), 32'(i < 4));
        end
        Contar_Negro_S = 0; rst_cont = 1;
        tick();
        chk("rc_cn", 32'(CN), 0);
        chk("rc_cb", 32'(CB), 0);
        clr();

        // overflow with stalled sink
        wr_ready = 0;
        for (int i = 0; i < 6; i++) begin
            paint = 1; Change_X = 1; sum = 1; px_data = 8'($urandom);
            tick();
        end
        clr();
        chk("ovf_set", 32'(overflow), 1);
        seen.delete();
        wr_ready = 1;
        repeat (6) tick();
        chk("ovf_drain", 32'(seen.size()), 4);

        // full plus simultaneous paint/drain
        do_reset();
        wr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            paint = 1; px_data = 8'($urandom); Change_Y = 1; sum = 1;
            tick();
        end
        clr();
        paint = 1; px_data = 8'hA5; wr_ready = 1;
        tick();
        chk("full_noovf", 32'(overflow), 0);
        paint = 0; wr_ready = 0;
        tick();
        seen.delete();
        wr_ready = 1;
        repeat (6) tick();
        chk("full_cnt", 32'(seen.size()), 4);

        // reset with entries pending
        wr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            paint = 1; px_data = 8'($urandom);
            tick();
        end
        paint = 0; wr_ready = 1;
        tick();
        wr_ready = 0; plus = 1;
        repeat (2) tick();
        chk("pre_rst_c", 32'(C), 2);
        plus = 0; rst = 0;
        tick();
        rst = 1;
        chk("mid_rst_v", 32'(wr_valid), 0);
        chk("mid_rst_c", 32'(C), 0);
        chk("mid_rst_o", 32'(overflow), 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            base_x = 5'($urandom); base_y = 5'($urandom);
            out_rst = ($urandom_range(0, 15) == 0);
            rst_cont = ($urandom_range(0, 11) == 0);
            plus = 1'($urandom); sum = 1'($urandom);
            Change_X = 1'($urandom); Change_Y = ($urandom_range(0, 3) == 0);
            paint = 1'($urandom); px_data = 8'($urandom);
            Contar_Blanco_S = ($urandom_range(0, 7) != 0);
            Contar_Negro_S = ($urandom_range(0, 3) == 0);
            wr_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1;
        clr();
        wr_ready = 1;
        repeat (8) tick();
        chk("final_empty", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
